// File: rtl/gpu_pkg.sv
// Shared types for the GPU blit front end: walker states, pixel size, command bundle.
// Latency: n/a (types and a helper function only).
// Backpressure: n/a.
package gpu_pkg;

  localparam int GPU_COORD_W = 16;
  localparam int GPU_ADDR_W  = 32;
  localparam int GPU_SCALE_W = 4;

  // Pixels are 16-bit; every address in this block is a byte address.
  localparam int PIXEL_BYTES = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } walker_state_e;

  // Full payload of one blit command as presented on the re_* port group.
  typedef struct packed {
    logic [GPU_ADDR_W-1:0]  base_address;
    logic [GPU_COORD_W-1:0] image_width;
    logic [GPU_COORD_W-1:0] src_x;
    logic [GPU_COORD_W-1:0] src_y;
    logic [GPU_COORD_W-1:0] width;
    logic [GPU_COORD_W-1:0] height;
    logic [GPU_COORD_W-1:0] dst_x;
    logic [GPU_COORD_W-1:0] dst_y;
    logic [GPU_SCALE_W-1:0] scale_x;
    logic [GPU_SCALE_W-1:0] scale_y;
    logic                   flip_x;
    logic                   flip_y;
  } blit_cmd_t;

  // A scale factor of zero means "no scaling".
  function automatic logic [GPU_SCALE_W-1:0] eff_scale(input logic [GPU_SCALE_W-1:0] s);
    return (s == '0) ? GPU_SCALE_W'(1) : s;
  endfunction

endpackage

// File: rtl/gpu_axis_counter.sv
// One walk axis: source index + repeat counter, destination coordinate and an address accumulator.
// Latency: load takes effect next cycle; every step_i advances state by one beat on that axis.
// Backpressure: state only moves when step_i is high, so the caller stalls it by withholding step_i.
// Ports: load_i latches size/scale/flip/dst/accumulator start+stride; step_i advances one beat;
//        dst_o = current destination coordinate, acc_o = current address contribution,
//        done_o = last index and last repeat (next step wraps back to the start).
module gpu_axis_counter
  import gpu_pkg::*;
#(
  parameter int COORD_W = GPU_COORD_W,
  parameter int ADDR_W  = GPU_ADDR_W,
  parameter int SCALE_W = GPU_SCALE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [COORD_W-1:0] size_i,
  input  logic [COORD_W-1:0] dst_i,
  input  logic [SCALE_W-1:0] scale_i,
  input  logic               flip_i,
  input  logic [ADDR_W-1:0]  acc_init_i,
  input  logic [ADDR_W-1:0]  acc_step_i,
  output logic [COORD_W-1:0] dst_o,
  output logic [ADDR_W-1:0]  acc_o,
  output logic               done_o
);

  logic [COORD_W-1:0] size_q, dst0_q;
  logic [SCALE_W-1:0] scale_q;
  logic               flip_q;
  logic [ADDR_W-1:0]  init_q, stride_q;

  logic [COORD_W-1:0] idx_q, idx_d, dst_q, dst_d;
  logic [SCALE_W-1:0] rep_q, rep_d;
  logic [ADDR_W-1:0]  acc_q, acc_d;

  assign done_o = (idx_q == size_q - 1'b1) && (rep_q == scale_q - 1'b1);
  assign dst_o  = dst_q;
  assign acc_o  = acc_q;

  always_comb begin
    idx_d = idx_q;
    rep_d = rep_q;
    dst_d = dst_q;
    acc_d = acc_q;
    if (load_i) begin
      idx_d = '0;
      rep_d = '0;
      dst_d = dst_i;
      acc_d = acc_init_i;
    end else if (step_i) begin
      if (done_o) begin
        // Wrap to the start of the axis for the next row (or next command).
        idx_d = '0;
        rep_d = '0;
        dst_d = dst0_q;
        acc_d = init_q;
      end else begin
        dst_d = dst_q + 1'b1;
        if (rep_q == scale_q - 1'b1) begin
          rep_d = '0;
          idx_d = idx_q + 1'b1;
          // The start value already points at the mirrored end, so a mirrored axis walks backwards.
          acc_d = flip_q ? acc_q - stride_q : acc_q + stride_q;
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      rep_q <= '0;
    end else begin
      idx_q <= idx_d;
      rep_q <= rep_d;
    end
    dst_q <= dst_d;
    acc_q <= acc_d;
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      size_q   <= size_i;
      scale_q  <= scale_i;
      flip_q   <= flip_i;
      dst0_q   <= dst_i;
      init_q   <= acc_init_i;
      stride_q <= acc_step_i;
    end
  end

endmodule

// File: rtl/gpu_blit_walker.sv
// Blit walker: takes one command, emits one beat (source byte address + dst x/y) per destination pixel.
// Latency: first beat the cycle after the command handshake, then 1 beat/cycle; one idle cycle between commands.
// Backpressure: se_* hold while se_ready=0; re_ready is only high in IDLE.
// Ports: clk/rst (sync, active-high); re_* command handshake and payload;
//        se_valid/se_ready beat handshake, se_address, se_dst_x/se_dst_y, se_last on the final beat.
module gpu_blit_walker
  import gpu_pkg::*;
#(
  parameter int COORD_W = GPU_COORD_W,
  parameter int ADDR_W  = GPU_ADDR_W,
  parameter int SCALE_W = GPU_SCALE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               re_valid,
  output logic               re_ready,
  input  logic [ADDR_W-1:0]  re_base_address,
  input  logic [COORD_W-1:0] re_image_width,
  input  logic [COORD_W-1:0] re_src_x,
  input  logic [COORD_W-1:0] re_src_y,
  input  logic [COORD_W-1:0] re_width,
  input  logic [COORD_W-1:0] re_height,
  input  logic [COORD_W-1:0] re_dst_x,
  input  logic [COORD_W-1:0] re_dst_y,
  input  logic [SCALE_W-1:0] re_scale_x,
  input  logic [SCALE_W-1:0] re_scale_y,
  input  logic               re_flip_x,
  input  logic               re_flip_y,
  output logic               se_valid,
  input  logic               se_ready,
  output logic [ADDR_W-1:0]  se_address,
  output logic [COORD_W-1:0] se_dst_x,
  output logic [COORD_W-1:0] se_dst_y,
  output logic               se_last
);

  blit_cmd_t     cmd;
  walker_state_e state_q, state_d;
  logic          re_ready_q, re_ready_d;
  logic          accept, load, beat_hs, x_done, y_done;
  logic [COORD_W-1:0] ex0, ey0;
  logic [ADDR_W-1:0]  col_step, row_step, col_init, row_init, col_acc, row_acc;

  always_comb begin
    cmd.base_address = re_base_address;
    cmd.image_width  = re_image_width;
    cmd.src_x        = re_src_x;
    cmd.src_y        = re_src_y;
    cmd.width        = re_width;
    cmd.height       = re_height;
    cmd.dst_x        = re_dst_x;
    cmd.dst_y        = re_dst_y;
    cmd.scale_x      = eff_scale(re_scale_x);
    cmd.scale_y      = eff_scale(re_scale_y);
    cmd.flip_x       = re_flip_x;
    cmd.flip_y       = re_flip_y;
  end

  assign accept   = re_valid && re_ready_q;
  // Empty rectangles are consumed without leaving IDLE.
  assign load     = accept && (cmd.width != '0) && (cmd.height != '0);
  assign se_valid = (state_q == RUN);
  assign beat_hs  = se_valid && se_ready;
  assign se_last  = se_valid && x_done && y_done;
  assign re_ready = re_ready_q;
  assign se_address = row_acc + col_acc;

  // Start addresses for the first beat; the row start is the only multiply and runs at latch time.
  always_comb begin
    ex0      = cmd.flip_x ? cmd.width - 1'b1 : '0;
    ey0      = cmd.flip_y ? cmd.height - 1'b1 : '0;
    col_step = ADDR_W'(PIXEL_BYTES);
    row_step = ADDR_W'(PIXEL_BYTES) * ADDR_W'(cmd.image_width);
    col_init = col_step * (ADDR_W'(cmd.src_x) + ADDR_W'(ex0));
    row_init = cmd.base_address + row_step * (ADDR_W'(cmd.src_y) + ADDR_W'(ey0));
  end

  gpu_axis_counter #(.COORD_W(COORD_W), .ADDR_W(ADDR_W), .SCALE_W(SCALE_W)) u_x_axis (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .step_i     (beat_hs),
    .size_i     (cmd.width),
    .dst_i      (cmd.dst_x),
    .scale_i    (cmd.scale_x),
    .flip_i     (cmd.flip_x),
    .acc_init_i (col_init),
    .acc_step_i (col_step),
    .dst_o      (se_dst_x),
    .acc_o      (col_acc),
    .done_o     (x_done)
  );

  // The row axis only moves when the column axis wraps.
  gpu_axis_counter #(.COORD_W(COORD_W), .ADDR_W(ADDR_W), .SCALE_W(SCALE_W)) u_y_axis (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .step_i     (beat_hs && x_done),
    .size_i     (cmd.height),
    .dst_i      (cmd.dst_y),
    .scale_i    (cmd.scale_y),
    .flip_i     (cmd.flip_y),
    .acc_init_i (row_init),
    .acc_step_i (row_step),
    .dst_o      (se_dst_y),
    .acc_o      (row_acc),
    .done_o     (y_done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = RUN;
      RUN:     if (beat_hs && se_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Registered ready stays low through reset and rises the first cycle after it.
    re_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      re_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      re_ready_q <= re_ready_d;
    end
  end

endmodule

// File: tb/tb_gpu_blit_walker.sv
// Bench for gpu_blit_walker: directed scenarios plus random commands against a loop-based model.
// Latency: n/a.
// Backpressure: se_ready is driven directly or randomised by the bench.
module tb_gpu_blit_walker;
  import gpu_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] dx;
    logic [15:0] dy;
    logic        last;
  } beat_t;

  logic        clk, rst, re_valid, re_ready, se_valid, se_ready, se_last;
  logic [31:0] se_address;
  logic [15:0] se_dst_x, se_dst_y;
  blit_cmd_t   drv, c;
  beat_t       exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic        rand_rdy = 1'b0;

  gpu_blit_walker dut (
    .clk(clk), .rst(rst),
    .re_valid(re_valid), .re_ready(re_ready),
    .re_base_address(drv.base_address), .re_image_width(drv.image_width),
    .re_src_x(drv.src_x), .re_src_y(drv.src_y),
    .re_width(drv.width), .re_height(drv.height),
    .re_dst_x(drv.dst_x), .re_dst_y(drv.dst_y),
    .re_scale_x(drv.scale_x), .re_scale_y(drv.scale_y),
    .re_flip_x(drv.flip_x), .re_flip_y(drv.flip_y),
    .se_valid(se_valid), .se_ready(se_ready),
    .se_address(se_address), .se_dst_x(se_dst_x), .se_dst_y(se_dst_y),
    .se_last(se_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: enumerate destination pixels row-major and map each back to its source pixel.
  task automatic push_model(input blit_cmd_t m);
    int scx, scy, nx, ny, sx, sy, ex, ey;
    beat_t b;
    scx = (m.scale_x == 0) ? 1 : int'(m.scale_x);
    scy = (m.scale_y == 0) ? 1 : int'(m.scale_y);
    nx = int'(m.width) * scx;
    ny = int'(m.height) * scy;
    for (int j = 0; j < ny; j++) begin
      for (int k = 0; k < nx; k++) begin
        sx = k / scx;
        sy = j / scy;
        ex = m.flip_x ? int'(m.width) - 1 - sx : sx;
        ey = m.flip_y ? int'(m.height) - 1 - sy : sy;
        b.addr = m.base_address + 32'(2 * ((int'(m.src_y) + ey) * int'(m.image_width) + int'(m.src_x) + ex));
        b.dx   = m.dst_x + 16'(k);
        b.dy   = m.dst_y + 16'(j);
        b.last = (j == ny - 1) && (k == nx - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic send_cmd(input blit_cmd_t m);
    int n = 0;
    while (!re_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("cmd_ready", re_ready, 1);
    if (re_ready) begin
      drv = m;
      re_valid = 1'b1;
      @(posedge clk); #1;
      re_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_q.size() != 0 || se_valid) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_left", exp_q.size(), 0);
    check_eq("drain_vld", se_valid, 0);
  endtask

  task automatic run_cmd(input blit_cmd_t m);
    push_model(m);
    send_cmd(m);
    wait_done();
  endtask

  function automatic blit_cmd_t base_cmd();
    blit_cmd_t m;
    m = '0;
    m.base_address = 32'h1000;
    m.image_width  = 16'd8;
    m.src_x = 16'd1;  m.src_y = 16'd1;
    m.width = 16'd2;  m.height = 16'd2;
    m.dst_x = 16'd10; m.dst_y = 16'd20;
    m.scale_x = 4'd1; m.scale_y = 4'd1;
    return m;
  endfunction

  // Beat monitor: compares accepted beats with the model, checks hold under stall and the post-last cycle.
  initial begin
    logic  stall_seen = 1'b0;
    logic  last_seen = 1'b0;
    beat_t h, e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_seen = 1'b0;
        last_seen = 1'b0;
      end else begin
        if (last_seen) begin
          check_eq("post_last_vld", se_valid, 0);
          check_eq("post_last_rdy", re_ready, 1);
          last_seen = 1'b0;
        end
        if (stall_seen) begin
          check_eq("hold_vld", se_valid, 1);
          check_eq("hold_addr", se_address, h.addr);
          check_eq("hold_dx", se_dst_x, h.dx);
          check_eq("hold_dy", se_dst_y, h.dy);
          check_eq("hold_last", se_last, h.last);
        end
        stall_seen = se_valid && !se_ready;
        h.addr = se_address; h.dx = se_dst_x; h.dy = se_dst_y; h.last = se_last;
        if (se_valid && se_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("addr", se_address, e.addr);
            check_eq("dst_x", se_dst_x, e.dx);
            check_eq("dst_y", se_dst_y, e.dy);
            check_eq("last", se_last, e.last);
            last_seen = se_last;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) se_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    rst = 1'b1;
    re_valid = 1'b0;
    se_ready = 1'b1;
    drv = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", re_ready, 0);
    check_eq("rst_valid", se_valid, 0);
    check_eq("rst_last", se_last, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("ready_after_rst", re_ready, 1);

    c = base_cmd();
    run_cmd(c);
    c.flip_x = 1'b1;
    run_cmd(c);
    c = base_cmd();
    c.flip_y = 1'b1;
    run_cmd(c);
    c = '0;
    c.width = 16'd1; c.height = 16'd1; c.scale_x = 4'd2; c.scale_y = 4'd2;
    run_cmd(c);
    c.scale_x = 4'd0;
    run_cmd(c);

    // Stall the second beat for three cycles.
    c = base_cmd();
    push_model(c);
    send_cmd(c);
    @(posedge clk); #1;
    se_ready = 1'b0;
    repeat (3) begin
      check_eq("bp_addr", se_address, 32'h1014);
      check_eq("bp_dx", se_dst_x, 32'd11);
      check_eq("bp_dy", se_dst_y, 32'd20);
      @(posedge clk); #1;
    end
    se_ready = 1'b1;
    wait_done();

    // Empty rectangle is swallowed.
    c = base_cmd();
    c.width = 16'd0;
    send_cmd(c);
    repeat (4) begin
      check_eq("zw_ready", re_ready, 1);
      check_eq("zw_valid", se_valid, 0);
      @(posedge clk); #1;
    end

    // Reset on the second beat aborts the command.
    c = base_cmd();
    push_model(c);
    send_cmd(c);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check_eq("abort_valid", se_valid, 0);
    check_eq("abort_ready", re_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_ready2", re_ready, 1);
    run_cmd(base_cmd());

    rand_rdy = 1'b1;
    repeat (40) begin
      c.base_address = $urandom;
      c.image_width  = 16'($urandom_range(1, 300));
      c.src_x   = 16'($urandom_range(0, 100));
      c.src_y   = 16'($urandom_range(0, 100));
      c.width   = 16'($urandom_range(0, 4));
      c.height  = 16'($urandom_range(0, 3));
      c.dst_x   = 16'($urandom);
      c.dst_y   = 16'($urandom);
      c.scale_x = 4'($urandom_range(0, 3));
      c.scale_y = 4'($urandom_range(0, 3));
      c.flip_x  = 1'($urandom_range(0, 1));
      c.flip_y  = 1'($urandom_range(0, 1));
      run_cmd(c);
    end
    rand_rdy = 1'b0;
    se_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
